// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver FSM encoding and parity helper.
// Used by both uart_tx and uart_rx so the two ends agree on parity sense.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    // Bit a transmitter appends so that data plus parity has the requested sense.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; resets to 1 so an
// idle-high serial line looks idle while reset is asserted.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Single-byte UART receiver: mid-bit sampling of a synchronized rx line,
// optional parity, stop-bit check and a one-entry valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIVIDER = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      valid,
    input  logic                      ready,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      parity_error,
    output logic                      frame_error,
    output logic                      overrun,
    output logic                      busy,
    input  logic [11:0]               baud_divider,
    input  logic                      parity_en,
    input  logic                      parity_type_odd
);

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_START     = START;
    localparam logic [2:0] S_DATA      = DATA;
    localparam logic [2:0] S_PARITY    = PARITY;
    localparam logic [2:0] S_STOP      = STOP;
    localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;

    logic                      rs;
    logic [2:0]                state;
    logic [11:0]               cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [11:0]               n_q;
    logic                      par_en_q;
    logic                      odd_q;
    logic                      perr_q;
    logic [11:0]               n_eff;
    logic                      sample;
    logic                      byte_done;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rs)
    );

    assign n_eff     = (baud_divider < 12'(MIN_DIVIDER)) ? 12'(MIN_DIVIDER) : baud_divider;
    assign sample    = (cnt == 12'd0);
    assign byte_done = (state == S_STOP) && sample;
    assign busy      = (state != S_IDLE);

    // Frame sequencer; the counter is reloaded on each sample so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            n_q      <= 12'(MIN_DIVIDER);
            par_en_q <= 1'b0;
            odd_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rs) begin
                        state    <= S_START;
                        cnt      <= {1'b0, n_eff[11:1]} - 12'd1;
                        n_q      <= n_eff;
                        par_en_q <= parity_en;
                        odd_q    <= parity_type_odd;
                        perr_q   <= 1'b0;
                        bit_idx  <= '0;
                    end
                end
                S_START: begin
                    if (sample) begin
                        if (rs) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                            cnt   <= n_q - 12'd1;
                        end
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        shift   <= {rs, shift[UART_DATA_BITS-1:1]};
                        cnt     <= n_q - 12'd1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            state <= par_en_q ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                S_PARITY: begin
                    if (sample) begin
                        perr_q <= (rs != parity_bit(shift, odd_q));
                        cnt    <= n_q - 12'd1;
                        state  <= S_STOP;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        state <= rs ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt - 12'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rs) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Holding register: a completed byte loads only if the slot is free or
    // being drained on this same edge; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid        <= 1'b0;
            data         <= '0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= byte_done && valid && !ready;
            if (byte_done && (!valid || ready)) begin
                valid        <= 1'b1;
                data         <= shift;
                parity_error <= perr_q;
                frame_error  <= !rs;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of parity/divider frames plus hand-written
// sequences for exact latency, framing error, glitch, overrun and reset.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        valid;
    logic        ready;
    logic [7:0]  data;
    logic        parity_error;
    logic        frame_error;
    logic        overrun;
    logic        busy;
    logic [11:0] baud_divider;
    logic        parity_en;
    logic        parity_type_odd;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ovr_cnt = 0;
    logic [9:0]  got_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [11:0] div;
        int          cpb;
        bit          pen;
        bit          odd;
        bit          pbit;
        bit          exp_perr;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_rx dut (
        .clk             (clk),
        .rst             (rst),
        .rx              (rx),
        .valid           (valid),
        .ready           (ready),
        .data            (data),
        .parity_error    (parity_error),
        .frame_error     (frame_error),
        .overrun         (overrun),
        .busy            (busy),
        .baud_divider    (baud_divider),
        .parity_en       (parity_en),
        .parity_type_odd (parity_type_odd)
    );

    // Capture every accepted byte as {parity_error, frame_error, data}.
    always @(negedge clk) begin
        if (valid && ready) got_q.push_back({parity_error, frame_error, data});
        if (overrun) ovr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [11:0] div, input bit pen, input bit odd);
        baud_divider    = div;
        parity_en       = pen;
        parity_type_odd = odd;
    endtask

    task automatic send_bit(input bit b, input int cpb);
        rx = b;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int cpb, input bit pen,
                              input bit pbit, input bit stop_b, input int stop_cycles);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
        if (pen) send_bit(pbit, cpb);
        send_bit(stop_b, stop_cycles);
    endtask

    task automatic wait_byte(input string name, input int max_cycles, output logic [9:0] r);
        int i = 0;
        while (got_q.size() == 0 && i < max_cycles) begin
            @(negedge clk);
            i++;
        end
        if (got_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no byte expected one within %0d cycles", name, max_cycles);
            r = '0;
        end else begin
            r = got_q.pop_front();
        end
    endtask

    initial begin
        logic [9:0] r;
        int         ovr0;

        vecs[0] = '{8'h3C, 12'd10,  10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 12'd10,  10, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 12'd8,    8, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 12'd2,    4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h6B, 12'd12,  12, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hC3, 12'd100, 100, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 12'd5,    5, 1'b0, 1'b1, 1'b0, 1'b0};

        rst   = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        set_cfg(12'd16, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_data", data, 8'h00);
        check("reset_perr", parity_error, 0);
        check("reset_ferr", frame_error, 0);
        check("reset_overrun", overrun, 0);
        check("reset_busy", busy, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Exact latency: 0xA5, N=16, valid 155 edges after rx falls (2 sync + 153).
        fork
            send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (2) @(negedge clk);
                check("a5_busy_before", busy, 0);
                @(negedge clk);
                check("a5_busy_rise", busy, 1);
                repeat (151) @(negedge clk);
                check("a5_valid_early", valid, 0);
                @(negedge clk);
                check("a5_valid", valid, 1);
                check("a5_data", data, 8'hA5);
                check("a5_perr", parity_error, 0);
                check("a5_ferr", frame_error, 0);
                @(negedge clk);
                check("a5_busy_low", busy, 0);
            end
        join
        got_q.delete();
        repeat (3) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v].div, vecs[v].pen, vecs[v].odd);
            send_frame(vecs[v].data, vecs[v].cpb, vecs[v].pen, vecs[v].pbit, 1'b1, vecs[v].cpb);
            wait_byte($sformatf("vec%0d_wait", v), 4 * vecs[v].cpb, r);
            check($sformatf("vec%0d_data", v), r[7:0], vecs[v].data);
            check($sformatf("vec%0d_perr", v), r[9], vecs[v].exp_perr);
            check($sformatf("vec%0d_ferr", v), r[8], 0);
            repeat (3) @(negedge clk);
        end

        // Stop bit low with the line held low: framing error, then WAIT_IDLE.
        set_cfg(12'd16, 1'b0, 1'b0);
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 30);
        wait_byte("ferr_wait", 40, r);
        check("ferr_data", r[7:0], 8'h55);
        check("ferr_flag", r[8], 1);
        check("ferr_busy_held", busy, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("ferr_busy_low", busy, 0);
        check("ferr_no_extra", got_q.size(), 0);

        // Short glitch: false start, then a real frame.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_byte", got_q.size(), 0);
        check("glitch_busy", busy, 0);
        send_frame(8'h81, 16, 1'b0, 1'b0, 1'b1, 16);
        wait_byte("glitch_next_wait", 40, r);
        check("glitch_next_data", r[7:0], 8'h81);
        repeat (3) @(negedge clk);

        // Overrun: consumer stalled across two back-to-back frames.
        ready = 1'b0;
        ovr0  = ovr_cnt;
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b1, 16);
        send_frame(8'h22, 16, 1'b0, 1'b0, 1'b1, 16);
        repeat (5) @(negedge clk);
        check("ovr_valid", valid, 1);
        check("ovr_data", data, 8'h11);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_drain", valid, 0);
        repeat (30) @(negedge clk);
        check("ovr_stay_low", valid, 0);
        check("ovr_count", got_q.size(), 1);
        wait_byte("ovr_pop", 1, r);
        check("ovr_pop_data", r[7:0], 8'h11);

        // Reset mid-DATA of 0xF0.
        set_cfg(12'd16, 1'b0, 1'b0);
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 16);
        rst = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 8'h00);
        check("rst_overrun", overrun, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_after_busy", busy, 0);
        check("rst_no_byte", got_q.size(), 0);
        send_frame(8'h0F, 16, 1'b0, 1'b0, 1'b1, 16);
        wait_byte("rst_next_wait", 40, r);
        check("rst_next_data", r[7:0], 8'h0F);
        check("rst_next_ferr", r[8], 0);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Single-byte UART receiver core, the receive counterpart of the existing uart_tx.
- Samples an asynchronous rx line and checks start, parity and stop bits.
- Presents each received byte with per-byte error status on a valid/ready output port, backed by one holding register.
- Sits between the pad and an optional RX FIFO. Its configuration inputs match uart_tx, so one config register block drives both.

Parameters:
- SYNC_STAGES, 2, number of flops in the rx input synchronizer (minimum 2).
- MIN_DIVIDER, 4, smallest effective clocks-per-bit; smaller baud_divider values are clamped up to this.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock domain, asynchronous assertion, active-low (rst=0 resets)
- rx  in  1  serial input, idle high, asynchronous to clk
- valid  out  1  output byte available; held until accepted
- ready  in  1  consumer accepts the byte when valid && ready at a rising edge
- data  out  8  received byte, LSB received first
- parity_error  out  1  status of the byte on data; meaningful only while valid
- frame_error  out  1  stop bit sampled low for the byte on data; meaningful only while valid
- overrun  out  1  one-cycle pulse: a completed byte was dropped
- busy  out  1  high from start detection until return to IDLE
- baud_divider  in  12  clocks per bit (N); effective N = max(baud_divider, MIN_DIVIDER)
- parity_en  in  1  a parity bit follows the data bits
- parity_type_odd  in  1  1 = odd parity, 0 = even parity

Behaviour:
- Reset values: valid=0, data=8'h00, parity_error=0, frame_error=0, overrun=0, busy=0, FSM=IDLE, synchronizer flops=1.
- Reset mid-frame aborts the frame; no output is produced.
- Configuration: N, parity_en and parity_type_odd are latched at start detection; changes mid-frame are ignored.
- rs denotes the synchronized rx. Let d be the first cycle in which IDLE observes rs=0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - rs=0 -> START; bit counter loaded with N/2-1 (integer division).
  - busy rises in cycle d+1.
- START:
  - Sample at counter expiry, i.e. cycle d+N/2.
  - rs=1 -> false start: IDLE, no output, no flags.
  - rs=0 -> DATA; counter reloaded with N-1.
- DATA:
  - 8 samples, one every N cycles, shifted in LSB first.
  - After the 8th sample -> PARITY if parity_en, else STOP.
- PARITY:
  - One sample.
  - Error if (XOR of data bits ^ parity bit) != parity_type_odd.
- STOP:
  - One sample; rs=0 sets frame_error for this byte.
  - Last sample falls at d+N/2+(9+parity_en)*N.
  - The byte completes in the cycle after the stop sample.
  - Next state: rs=1 -> IDLE; rs=0 -> WAIT_IDLE.
- WAIT_IDLE: stay until rs=1 (break/line-low handling), then IDLE. busy remains high.
- Byte completion, holding register empty or accepted in the same cycle (valid=0, or valid && ready):
  - data and both error flags are loaded.
  - valid=1 in the cycle after the stop sample.
- Byte completion while valid && !ready:
  - The new byte is discarded and the held byte is unchanged.
  - overrun pulses high for exactly one cycle.
- valid deasserts on the edge where valid && ready, unless a new byte loads on that same edge; then valid stays 1 with the new contents.
- A new start bit is accepted in the first IDLE cycle; back-to-back frames with a single stop bit must be received without loss.
- Counters:
  - Bit counter is 12 bits, decrementing, samples at 0.
  - Bit index is a 3-bit counter.
  - No arithmetic overflow for N up to 4095.

Decomposition:
- Package uart_pkg, shared with uart_tx:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE};
  - function parity_bit(data, odd);
  - localparam UART_DATA_BITS = 8.
- One sub-module: sync_ff (parameterized SYNC_STAGES-deep synchronizer, reset value 1) on rx.

Test Plan:
- Frame 0xA5, N=16, no parity, ready=1 -> valid exactly at cycle d+8+9*16+1 = d+153; data=8'hA5; both errors=0; busy low one cycle later.
- Frame 0x3C, N=10, parity_en=1:
  - Even parity, bit=0 -> parity_error=0.
  - Odd parity with the same bit=0 -> parity_error=1; data still 8'h3C.
- Stop bit forced low on 0x55, rx held low for 30 cycles -> valid with frame_error=1; FSM stays in WAIT_IDLE (busy=1) until rx rises; no spurious second byte.
- Glitch: rx low for 3 cycles with N=16 -> false start; no valid, busy returns to 0, next real frame 0x81 received correctly.
- ready=0; frames 0x11 then 0x22 back-to-back -> data stays 8'h11, overrun pulses once at completion of 0x22; after ready=1, valid drops and nothing else is delivered.
- Reset (rst=0) asserted mid-DATA of frame 0xF0, then released with rx idle -> all outputs at reset values; no valid; next frame 0x0F received correctly.
